// File: rtl/chart_note_sequencer.sv
// Chart player: walks a beatmap in a synchronous ROM and raises {ka, do} note requests
// on the frame tick at which each entry becomes due.
module chart_note_sequencer #(
    parameter int unsigned ADDR_W = 10,
    parameter bit          LOOP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] chart_addr,
    input  logic [15:0]       chart_data,
    output logic [1:0]        request,
    output logic              busy,
    output logic              done,
    output logic [15:0]       note_idx
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StWait, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrMax = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        req_q, req_d;
    logic [1:0]        req_pend_q, req_pend_d;
    logic [1:0]        mask_q, mask_d;
    logic [12:0]       cnt_q, cnt_d;
    logic              tick_pend_q, tick_pend_d;
    logic [15:0]       note_idx_q, note_idx_d;

    logic              tick;
    logic              emit;
    logic [1:0]        pop;
    logic [16:0]       note_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            req_q       <= 2'b00;
            req_pend_q  <= 2'b00;
            mask_q      <= 2'b00;
            cnt_q       <= '0;
            tick_pend_q <= 1'b0;
            note_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            req_pend_q  <= req_pend_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            tick_pend_q <= tick_pend_d;
            note_idx_q  <= note_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        req_d       = req_q;
        req_pend_d  = req_pend_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        tick_pend_d = tick_pend_q;
        note_idx_d  = note_idx_q;
        tick        = 1'b0;
        emit        = 1'b0;
        pop         = {1'b0, mask_q[1]} + {1'b0, mask_q[0]};
        note_sum    = {1'b0, note_idx_q} + {15'd0, pop};

        unique case (state_q)
            StFetch: begin
                if (vsync && !pause) tick_pend_d = 1'b1;
                state_d = StLoad;
            end
            StLoad: begin
                if (vsync && !pause) tick_pend_d = 1'b1;
                if (chart_data[15]) begin
                    if (LOOP) begin
                        addr_d  = '0;
                        state_d = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    mask_d  = chart_data[14:13];
                    cnt_d   = (chart_data[12:0] == 13'd0) ? 13'd1 : chart_data[12:0];
                    state_d = StWait;
                end
            end
            StWait: begin
                tick = (vsync | tick_pend_q) & ~pause;
                // A real vsync coinciding with a pending tick survives as the next pending tick.
                tick_pend_d = tick_pend_q & vsync & ~pause;
                if (tick) begin
                    if (cnt_q == 13'd1) begin
                        emit       = 1'b1;
                        note_idx_d = note_sum[16] ? 16'hFFFF : note_sum[15:0];
                        if (addr_q == AddrMax) begin
                            if (LOOP) begin
                                addr_d  = '0;
                                state_d = StFetch;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = StFetch;
                        end
                    end else begin
                        cnt_d = cnt_q - 13'd1;
                    end
                end
            end
            default: ;
        endcase

        // Requests only move on vsync; an emission from a pending tick waits for the next one.
        if (vsync) begin
            req_d      = (emit ? mask_q : 2'b00) | req_pend_q;
            req_pend_d = 2'b00;
        end else if (emit) begin
            req_pend_d = req_pend_q | mask_q;
        end

        if (start) begin
            state_d     = StFetch;
            addr_d      = '0;
            note_idx_d  = '0;
            req_d       = 2'b00;
            req_pend_d  = 2'b00;
            tick_pend_d = 1'b0;
            cnt_d       = '0;
        end
    end

    assign chart_addr = addr_q;
    assign request    = req_q;
    assign note_idx   = note_idx_q;
    assign busy       = (state_q == StFetch) || (state_q == StLoad) || (state_q == StWait);
    assign done       = (state_q == StDone);

endmodule
